// File: rtl/key_onehot_capture.sv
// key_onehot_capture: synchronizes and debounces eight push-buttons, then captures the
// most recent single-key press as a registered one-hot code for the downstream 8-to-3 encoder.
module key_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_key,
  output logic [7:0] o_one_hot,
  output logic       o_valid,
  output logic       o_multi,
  output logic       o_any
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONE   = 2'd1,
    MULTI = 2'd2
  } state_t;

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] w_stable;
  logic [3:0] w_pop;
  logic       w_capture;
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_one_hot;
  logic       r_valid;
  logic       r_multi;
  logic       r_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce: the stable level flips only after an unbroken mismatch run.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
      logic [CW-1:0] r_cnt;
      logic          r_stable_bit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt        <= '0;
          r_stable_bit <= 1'b0;
        end else if (r_sync2[gi] == r_stable_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt        <= '0;
          r_stable_bit <= r_sync2[gi];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_stable[gi] = r_stable_bit;
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_stable[i]};
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop == 4'd1) begin
          w_capture    = 1'b1;
          w_state_next = ONE;
        end else if (w_pop >= 4'd2) begin
          w_state_next = MULTI;
        end
      end
      ONE: begin
        if (w_pop == 4'd0) begin
          w_state_next = IDLE;
        end else if (w_pop >= 4'd2) begin
          w_state_next = MULTI;
        end else if (w_stable != r_one_hot) begin
          // release of the old key and press of a new one resolved together
          w_capture = 1'b1;
        end
      end
      MULTI: begin
        if (w_pop == 4'd0) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_one_hot <= '0;
      r_valid   <= 1'b0;
      r_multi   <= 1'b0;
      r_any     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_capture;
      r_multi <= (w_state_next == MULTI);
      r_any   <= |w_stable;
      if (w_capture) begin
        r_one_hot <= w_stable;
      end
    end
  end

  assign o_one_hot = r_one_hot;
  assign o_valid   = r_valid;
  assign o_multi   = r_multi;
  assign o_any     = r_any;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Self-checking bench for key_onehot_capture: directed scenarios plus random key traffic,
// compared cycle by cycle against a behavioural model built from the key-handling rules.
module tb_key_onehot_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] i_key = 8'h00;
  logic [7:0] o_one_hot;
  logic       o_valid;
  logic       o_multi;
  logic       o_any;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  key_onehot_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_key     (i_key),
    .o_one_hot (o_one_hot),
    .o_valid   (o_valid),
    .o_multi   (o_multi),
    .o_any     (o_any)
  );

  // Reference model: raw keys delayed two samples, per-key mismatch run lengths,
  // and a capture rule driven by how many keys are currently held.
  logic [7:0] m_s1, m_s2, m_stable, m_ns, m_hot;
  int         m_run [8];
  int         m_state, m_state_n, m_n;
  logic       m_cap, m_valid, m_multi, m_any;

  always_comb begin
    m_ns = m_stable;
    for (int b = 0; b < 8; b++) begin
      if (m_s2[b] !== m_stable[b] && m_run[b] + 1 >= D) m_ns[b] = m_s2[b];
    end
  end

  always_comb begin
    m_n       = $countones(m_stable);
    m_cap     = 1'b0;
    m_state_n = m_state;
    if (m_n == 0) begin
      m_state_n = 0;
    end else if (m_n >= 2) begin
      m_state_n = 2;
    end else if (m_state == 0 || (m_state == 1 && m_stable != m_hot)) begin
      m_cap     = 1'b1;
      m_state_n = 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1     <= 8'h00;
      m_s2     <= 8'h00;
      m_stable <= 8'h00;
      m_hot    <= 8'h00;
      m_state  <= 0;
      m_valid  <= 1'b0;
      m_multi  <= 1'b0;
      m_any    <= 1'b0;
      for (int b = 0; b < 8; b++) m_run[b] <= 0;
    end else begin
      m_s1 <= i_key;
      m_s2 <= m_s1;
      for (int b = 0; b < 8; b++) begin
        m_run[b] <= (m_s2[b] !== m_stable[b] && m_run[b] + 1 < D) ? m_run[b] + 1 : 0;
      end
      m_stable <= m_ns;
      m_state  <= m_state_n;
      m_valid  <= m_cap;
      m_multi  <= (m_state_n == 2);
      m_any    <= (m_stable != 8'h00);
      if (m_cap) m_hot <= m_stable;
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({o_valid, o_multi, o_any, o_one_hot} !== 11'h000) begin
        fails++;
        $display("FAIL reset_outputs: got %h required 000", {o_valid, o_multi, o_any, o_one_hot});
      end
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({o_valid, o_multi, o_any, o_one_hot} !== 11'h000) begin
        fails++;
        $display("FAIL idle_after_reset: got %h required 000", {o_valid, o_multi, o_any, o_one_hot});
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    i_key = 8'h08;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'(c == 7)) begin
        fails++;
        $display("FAIL press_valid_edge%0d: got %b required %b", c, o_valid, c == 7);
      end
      checks++;
      if ({o_multi, o_any, o_one_hot} !== {m_multi, m_any, m_hot}) begin
        fails++;
        $display("FAIL press_model: got %h required %h", {o_multi, o_any, o_one_hot}, {m_multi, m_any, m_hot});
      end
    end
    checks++;
    if (o_one_hot !== 8'h08 || o_any !== 1'b1) begin
      fails++;
      $display("FAIL press_held: got onehot=%h any=%b required 08/1", o_one_hot, o_any);
    end
    i_key = 8'h00;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({o_valid, o_multi, o_any, o_one_hot} !== {m_valid, m_multi, m_any, m_hot}) begin
        fails++;
        $display("FAIL release_model: got %h required %h", {o_valid, o_multi, o_any, o_one_hot}, {m_valid, m_multi, m_any, m_hot});
      end
    end
    checks++;
    if (o_one_hot !== 8'h08 || o_any !== 1'b0) begin
      fails++;
      $display("FAIL release_hold: got onehot=%h any=%b required 08/0", o_one_hot, o_any);
    end
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    logic [7:0] lv;
    for (int k = 0; k < 4; k++) begin
      lv = (k % 2 == 0) ? 8'h20 : 8'h00;
      i_key = lv;
      repeat (2) begin
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
          fails++;
          $display("FAIL bounce_no_valid: got %b required 0", o_valid);
        end
      end
    end
    i_key = 8'h20;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'(c == D + 3)) begin
        fails++;
        $display("FAIL bounce_valid_edge%0d: got %b required %b", c, o_valid, c == D + 3);
      end
    end
    checks++;
    if (o_one_hot !== 8'h20) begin
      fails++;
      $display("FAIL bounce_capture: got %h required 20", o_one_hot);
    end
    i_key = 8'h00;
    repeat (20) @(negedge clk);
    $display("test_bounce done");
  endtask

  task automatic test_chord();
    int nv = 0;
    int nv_alone = 0;
    i_key = 8'h01;
    repeat (10) begin @(negedge clk); nv += int'(o_valid); end
    i_key = 8'h03;
    repeat (10) begin @(negedge clk); nv += int'(o_valid); end
    checks++;
    if (nv != 1 || o_one_hot !== 8'h01 || o_multi !== 1'b1) begin
      fails++;
      $display("FAIL chord_capture: got pulses=%0d onehot=%h multi=%b required 1/01/1", nv, o_one_hot, o_multi);
    end
    i_key = 8'h02;
    repeat (20) begin
      @(negedge clk);
      nv_alone += int'(o_valid);
      checks++;
      if ({o_valid, o_multi, o_any, o_one_hot} !== {m_valid, m_multi, m_any, m_hot}) begin
        fails++;
        $display("FAIL chord_model: got %h required %h", {o_valid, o_multi, o_any, o_one_hot}, {m_valid, m_multi, m_any, m_hot});
      end
    end
    checks++;
    if (nv_alone != 0 || o_multi !== 1'b1 || o_one_hot !== 8'h01) begin
      fails++;
      $display("FAIL chord_leftover: got pulses=%0d multi=%b onehot=%h required 0/1/01", nv_alone, o_multi, o_one_hot);
    end
    i_key = 8'h00;
    repeat (20) @(negedge clk);
    checks++;
    if (o_multi !== 1'b0 || o_any !== 1'b0) begin
      fails++;
      $display("FAIL chord_release: got multi=%b any=%b required 0/0", o_multi, o_any);
    end
    $display("test_chord done");
  endtask

  task automatic test_simultaneous();
    int nv = 0;
    i_key = 8'h81;
    repeat (20) begin @(negedge clk); nv += int'(o_valid); end
    checks++;
    if (nv != 0 || o_multi !== 1'b1 || o_one_hot !== 8'h01) begin
      fails++;
      $display("FAIL simultaneous: got pulses=%0d multi=%b onehot=%h required 0/1/01", nv, o_multi, o_one_hot);
    end
    i_key = 8'h00;
    repeat (20) @(negedge clk);
    $display("test_simultaneous done");
  endtask

  task automatic test_handover();
    int nv = 0;
    int nm = 0;
    i_key = 8'h04;
    repeat (15) @(negedge clk);
    checks++;
    if (o_one_hot !== 8'h04) begin
      fails++;
      $display("FAIL handover_first: got %h required 04", o_one_hot);
    end
    i_key = 8'h40;
    repeat (20) begin
      @(negedge clk);
      nv += int'(o_valid);
      nm += int'(o_multi);
    end
    checks++;
    if (nv != 1 || nm != 0 || o_one_hot !== 8'h40) begin
      fails++;
      $display("FAIL handover: got pulses=%0d multi_cycles=%0d onehot=%h required 1/0/40", nv, nm, o_one_hot);
    end
    i_key = 8'h00;
    repeat (20) @(negedge clk);
    $display("test_handover done");
  endtask

  task automatic test_reset_midpress();
    i_key = 8'h10;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_multi, o_any, o_one_hot} !== 11'h000) begin
      fails++;
      $display("FAIL midreset_immediate: got %h required 000", {o_valid, o_multi, o_any, o_one_hot});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({o_valid, o_multi, o_any, o_one_hot} !== 11'h000) begin
        fails++;
        $display("FAIL midreset_hold: got %h required 000", {o_valid, o_multi, o_any, o_one_hot});
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'(c == D + 3)) begin
        fails++;
        $display("FAIL midreset_valid_edge%0d: got %b required %b", c, o_valid, c == D + 3);
      end
    end
    checks++;
    if (o_one_hot !== 8'h10) begin
      fails++;
      $display("FAIL midreset_capture: got %h required 10", o_one_hot);
    end
    i_key = 8'h00;
    repeat (20) @(negedge clk);
    $display("test_reset_midpress done");
  endtask

  task automatic test_random();
    int sel;
    int hold;
    for (int t = 0; t < 80; t++) begin
      sel  = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 12));
      case (sel)
        0:       i_key = 8'h00;
        1:       i_key = 8'h01 << $urandom_range(0, 7);
        2:       i_key = 8'($urandom_range(0, 255));
        default: i_key = i_key;
      endcase
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if ({o_valid, o_multi, o_any, o_one_hot} !== {m_valid, m_multi, m_any, m_hot}) begin
          fails++;
          $display("FAIL random_model: key=%h got %h required %h", i_key, {o_valid, o_multi, o_any, o_one_hot}, {m_valid, m_multi, m_any, m_hot});
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_simultaneous();
    test_handover();
    test_reset_midpress();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
